// File: rtl/game_pkg.sv
// Shared encodings and widths for the round sequencer and its helpers.
package game_pkg;

  // Game-flow states as seen on the state output
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int SCORE_W = 16;
  localparam int TIME_W  = 7;
  localparam int LIVES_W = 2;

endpackage

// File: rtl/game_ctl_sec_tick.sv
// One-second strobe: counts 0..TICK_DIV-1 and pulses tick on the last count.
module sec_tick #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_main,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_tcnt;

  // Free-running divider, held at zero while clr is asserted
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (clr || (r_tcnt == LAST)) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign tick = (r_tcnt == LAST);

endmodule

// File: rtl/game_ctl.sv
// Round sequencer: game-flow FSM, lives, round countdown and high-score latch.
//
//   state | meaning
//   IDLE  | waiting for start; high score and new_high on display
//   CLEAR | one cycle; clears the score accumulator, round counters loaded
//   PLAY  | game logic enabled; hits cost lives, ticks cost seconds
//   OVER  | hold for OVER_SEC seconds while the high score is latched
module game_ctl
  import game_pkg::*;
#(
  parameter int LIVES     = 3,
  parameter int ROUND_SEC = 60,
  parameter int OVER_SEC  = 3,
  parameter int TICK_DIV  = 100_000_000
) (
  input  logic               clk_main,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               hit_me,
  input  logic [SCORE_W-1:0] score,
  output logic               rst_score,
  output logic               play,
  output logic [1:0]         state,
  output logic [LIVES_W-1:0] lives,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam int OVER_W = $clog2(OVER_SEC + 1);
  localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_SEC - 1);

  logic [1:0]         r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [TIME_W-1:0]  r_time;
  logic [SCORE_W-1:0] r_high;
  logic               r_new_high;
  logic [OVER_W-1:0]  r_over_cnt;
  logic               r_start_prev;
  logic               r_hit_prev;

  logic w_start_rise;
  logic w_hit_rise;
  logic w_tick;
  logic w_to_over;
  logic w_clr;

  assign w_start_rise = btn_start & ~r_start_prev;
  assign w_hit_rise   = hit_me & ~r_hit_prev;

  // Last life lost or last second elapsed; a coincident hit and tick still
  // makes only this one transition
  assign w_to_over = (r_state == ST_PLAY) &&
                     ((w_hit_rise && (r_lives == LIVES_W'(1))) ||
                      (w_tick && (r_time == TIME_W'(1))));

  // Divider restarts on OVER entry so the hold time is measured from there
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_CLEAR) || w_to_over;

  sec_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick (
    .clk_main(clk_main),
    .rst     (rst),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  // Previous-level registers for the button and collision edge detectors
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_start_prev <= 1'b0;
      r_hit_prev   <= 1'b0;
    end else begin
      r_start_prev <= btn_start;
      r_hit_prev   <= hit_me;
    end
  end

  // Game-flow FSM with the lives, countdown and high-score registers
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lives    <= '0;
      r_time     <= '0;
      r_high     <= '0;
      r_new_high <= 1'b0;
      r_over_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_state    <= ST_CLEAR;
            r_lives    <= LIVES_W'(LIVES);
            r_time     <= TIME_W'(ROUND_SEC);
            r_new_high <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (w_hit_rise && (r_lives != '0)) begin
            r_lives <= r_lives - 1'b1;
          end
          if (w_tick && (r_time != '0)) begin
            r_time <= r_time - 1'b1;
          end
          if (w_to_over) begin
            r_state    <= ST_OVER;
            r_over_cnt <= '0;
          end
        end
        ST_OVER: begin
          // Compared every cycle so the accumulator's final value is caught
          if (score > r_high) begin
            r_high     <= score;
            r_new_high <= 1'b1;
          end
          if (w_tick) begin
            if (r_over_cnt == OVER_LAST) begin
              r_state    <= ST_IDLE;
              r_over_cnt <= '0;
            end else begin
              r_over_cnt <= r_over_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rst_score  = (r_state == ST_CLEAR);
  assign play       = (r_state == ST_PLAY);
  assign state      = r_state;
  assign lives      = r_lives;
  assign time_left  = r_time;
  assign high_score = r_high;
  assign new_high   = r_new_high;

endmodule

// File: doc/game_ctl.md
# game_ctl

Round sequencer for the shooter game. It owns the game-flow state machine (idle, clear, play, game over) and drives `rst_score` into the score accumulator. It also tracks player lives and the round countdown, and latches the session high score from the accumulator's `score` output. It sits between the debounced button/collision logic and the score and seven-segment display blocks.

## Interface
Parameters:
- `LIVES`, 3: lives granted per round, 1..3
- `ROUND_SEC`, 60: round length in seconds, 1..127
- `OVER_SEC`, 3: game-over hold time in seconds before returning to idle, ≥1
- `TICK_DIV`, 100_000_000: `clk_main` cycles per second, ≥2

Ports:
- `clk_main`  in  1  system clock; one clock domain, all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `btn_start`  in  1  debounced start button (level); the rising edge acts
- `hit_me`  in  1  player-collision level; the rising edge costs one life
- `score`  in  16  current score from the score accumulator, registered there
- `rst_score`  out  1  clears the score accumulator
- `play`  out  1  enables game logic (movement, spawning, scoring)
- `state`  out  2  current state: IDLE=0, CLEAR=1, PLAY=2, OVER=3
- `lives`  out  2  remaining lives
- `time_left`  out  7  seconds remaining in the round
- `high_score`  out  16  best score since reset
- `new_high`  out  1  the last finished round set a new high score

## Operation
- Rising-edge detectors on `btn_start` and `hit_me` (rise = input & ~prev).
  - prev registers reset to 0, so an input held high through reset release yields one edge on the first cycle.
- The second counter `tcnt` counts 0..TICK_DIV-1 while in PLAY or OVER.
  - `tick` = (tcnt == TICK_DIV-1); the counter wraps to 0 after it.
  - `tcnt` is forced to 0 in IDLE and CLEAR and on every transition into OVER.
- IDLE: `play`=0.
  - Start rise → CLEAR. Hit rises are ignored.
- CLEAR: lasts exactly one cycle; `rst_score`=1 only in this state.
  - Loads `lives`←LIVES, `time_left`←ROUND_SEC, `new_high`←0.
  - → PLAY.
- PLAY: `play`=1.
  - Hit rise: `lives`←`lives`-1. If `lives`==1 at the hit, → OVER.
  - Tick: `time_left`←`time_left`-1. If `time_left`==1 at the tick, → OVER.
  - Hit and tick in the same cycle: both decrements apply and OVER is entered at most once.
  - `lives` and `time_left` saturate at 0 and never wrap.
  - Start rises are ignored.
- OVER: `play`=0.
  - Every cycle: if `score` > `high_score`, then `high_score`←`score` and `new_high`←1. The comparison is unsigned. Running it every cycle absorbs the accumulator's one-cycle latency.
  - A seconds counter counts ticks; after OVER_SEC ticks → IDLE.
  - Start and hit rises are ignored.
- `high_score` is cleared only by `rst`. `new_high` holds through IDLE until the next CLEAR.
- `rst_score` and `play` are decoded from the registered state and are glitch-free.

## Timing
- Reset values: state IDLE, `rst_score` 0, `play` 0, `lives` 0, `time_left` 0, `high_score` 0, `new_high` 0, `tcnt` 0, over-second counter 0.
- `rst` asserted at any time returns everything to the reset values at once, including in the middle of PLAY or OVER. Any round in progress is abandoned.
- Start rise sampled at edge k: CLEAR from k, PLAY from k+1, and `rst_score` is high for cycle k only.
- Hit rise sampled at edge k: `lives` updates at k.
- In PLAY, the first tick arrives TICK_DIV cycles after PLAY entry. A round with no hits lasts exactly ROUND_SEC×TICK_DIV cycles in PLAY.
- OVER lasts exactly OVER_SEC×TICK_DIV cycles.
- `high_score` may update on any OVER cycle; its final value is settled by the second OVER cycle.

## Structure
- Shared package `game_pkg` holds:
  - the state encoding localparams (IDLE, CLEAR, PLAY, OVER)
  - the width constants for `score`/`high_score` (16), `time_left` (7) and `lives` (2)
- Sub-module `sec_tick`:
  - parameter TICK_DIV; inputs `clk_main`, `rst` and synchronous `clr`; output `tick`
  - instantiated once.
- The rest is the FSM plus the lives, time and high-score registers, in a single module.

## Test plan
Bench parameters: TICK_DIV=4, ROUND_SEC=3, LIVES=3, OVER_SEC=2.
1. Reset, then a one-cycle `btn_start` pulse:
   - all outputs read 0 during reset;
   - then `state` goes 1 for exactly one cycle with `rst_score`=1;
   - then `state`=2, `lives`=3, `time_left`=3, `play`=1.
2. In PLAY, three `hit_me` pulses, the second one held high for 5 cycles:
   - `lives` goes 2, 1, then 0 with `state`=3;
   - the held level counts once.
3. No hits:
   - `time_left` steps 3→2→1→0, one step every 4 cycles, with OVER entered on the same edge as the 0;
   - `state` returns to 0 after 8 OVER cycles;
   - `btn_start` pulses during OVER are ignored.
4. High-score latching:
   - `score`=250 during OVER with `high_score`=0 → `high_score`=250, `new_high`=1;
   - next round with `score`=100 → `high_score` stays 250 and `new_high`=0 from CLEAR on.
5. Last-life hit on the same cycle as the final tick:
   - single OVER entry, `lives`=0, `time_left`=0, no wrap.
6. `rst` pulsed mid-PLAY with `high_score`=250:
   - immediate IDLE with `high_score`=0, `lives`=0, `play`=0.
